vc_out_alloc: RTL and testbench

//  Synchronous output-port VC allocator and credit tracker for one router output (S/W/N/E/L).

---
 rtl/noc_vc_pkg.sv | 26 ++
 rtl/rr_arb.sv | 38 +++
 rtl/vc_out_alloc.sv | 139 +++++++++++++
 tb/tb_vc_out_alloc.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_vc_pkg.sv
// Shared types and helpers for the output-port VC allocator.
// No logic of its own; sizes are derived from the instantiating module's parameters.
// No backpressure; definitions only.
package noc_vc_pkg;

    typedef enum logic {
        OVC_FREE = 1'b0,
        OVC_BUSY = 1'b1
    } ovc_state_e;

    // Ceiling log2; callers pass n >= 2 so the result is never zero-width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Flat request index of input port p, input VC v.
    function automatic int req_idx(input int p, input int v, input int vcn);
        return p * vcn + v;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// One-hot round-robin arbiter: first requester at or after ptr wins.
// Purely combinational, zero latency.
// No backpressure; the caller decides whether the winner is actually granted.
module rr_arb #(
    parameter int N  = 10,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] winner,
    output logic          any
);

    int            idx;
    logic [IW-1:0] sel;

    always_comb begin
        gnt    = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = IW'(idx);
            if (!any && req[sel]) begin
                any      = 1'b1;
                gnt[sel] = 1'b1;
                winner   = sel;
            end
        end
    end

endmodule

// File: rtl/vc_out_alloc.sv
// Output-port VC allocator and per-VC downstream credit tracker for one router output.
// Grant is registered: one cycle from a sampled request; credit-ok is combinational from the counters.
// Requests are held until granted; with no free output VC they simply wait.
module vc_out_alloc
    import noc_vc_pkg::*;
#(
    parameter int VCN  = 2,
    parameter int NIN  = 5,
    parameter int FCPD = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NIN*VCN-1:0]   req,
    output logic [NIN*VCN-1:0]   req_gnt,
    output logic [VCN-1:0]       gnt_ovc,
    input  logic                 flit_sent,
    input  logic [VCN-1:0]       flit_ovc,
    input  logic                 flit_tail,
    input  logic [VCN-1:0]       credit,
    output logic [VCN-1:0]       ovc_busy,
    output logic [VCN-1:0]       ovc_cr_ok,
    output logic                 err
);

    localparam int N  = NIN * VCN;
    localparam int IW = clog2(N);
    localparam int CW = clog2(FCPD + 1);

    ovc_state_e     st_q  [VCN];
    ovc_state_e     st_d  [VCN];
    logic [CW-1:0]  cnt_q [VCN];
    logic [CW-1:0]  cnt_d [VCN];

    logic [IW-1:0]  ptr_q;
    logic [IW-1:0]  winner;
    logic [N-1:0]   arb_req;
    logic [N-1:0]   arb_gnt;
    logic           arb_any;
    logic [VCN-1:0] busy;
    logic [VCN-1:0] free_sel;
    logic [VCN-1:0] snd;
    logic           any_free;
    logic           do_gnt;
    logic           flit_oh;
    logic           armed_q;
    logic           err_d;

    // The requester granted last cycle may still be asserting on this edge.
    assign arb_req = req & ~req_gnt;

    rr_arb #(
        .N  (N),
        .IW (IW)
    ) u_arb (
        .req    (arb_req),
        .ptr    (ptr_q),
        .gnt    (arb_gnt),
        .winner (winner),
        .any    (arb_any)
    );

    always_comb begin
        busy      = '0;
        ovc_cr_ok = '0;
        free_sel  = '0;
        any_free  = 1'b0;
        for (int v = 0; v < VCN; v++) begin
            busy[v]      = (st_q[v] == OVC_BUSY);
            ovc_cr_ok[v] = (cnt_q[v] != '0);
            if (!busy[v] && !any_free) begin
                free_sel[v] = 1'b1;
                any_free    = 1'b1;
            end
        end
    end

    assign ovc_busy = busy;
    assign do_gnt   = armed_q & arb_any & any_free;
    assign flit_oh  = $onehot(flit_ovc);
    assign snd      = (flit_sent && flit_oh) ? flit_ovc : '0;

    always_comb begin
        for (int v = 0; v < VCN; v++) begin
            st_d[v] = st_q[v];
            case (st_q[v])
                OVC_FREE: if (do_gnt && free_sel[v]) st_d[v] = OVC_BUSY;
                OVC_BUSY: if (snd[v] && flit_tail)   st_d[v] = OVC_FREE;
            endcase
        end
    end

    // A send and a credit on the same VC cancel; only lone events can over/underflow.
    always_comb begin
        err_d = err;
        if (flit_sent && !flit_oh) begin
            err_d = 1'b1;
        end
        for (int v = 0; v < VCN; v++) begin
            cnt_d[v] = cnt_q[v];
            if (snd[v] && !busy[v]) begin
                err_d = 1'b1;
            end
            if (snd[v] && busy[v]) begin
                if (!credit[v]) begin
                    if (cnt_q[v] == '0) err_d = 1'b1;
                    else                cnt_d[v] = cnt_q[v] - CW'(1);
                end
            end else if (credit[v]) begin
                if (cnt_q[v] == CW'(FCPD)) err_d = 1'b1;
                else                       cnt_d[v] = cnt_q[v] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int v = 0; v < VCN; v++) begin
                st_q[v]  <= OVC_FREE;
                cnt_q[v] <= CW'(FCPD);
            end
            ptr_q   <= '0;
            req_gnt <= '0;
            gnt_ovc <= '0;
            armed_q <= 1'b0;
            err     <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            armed_q <= 1'b1;
            err     <= err_d;
            req_gnt <= do_gnt ? arb_gnt : '0;
            gnt_ovc <= do_gnt ? free_sel : '0;
            if (do_gnt) begin
                ptr_q <= (winner == IW'(N - 1)) ? '0 : winner + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vc_out_alloc.sv
// Directed bench for vc_out_alloc with a cycle-level behavioural model and literal spot checks.
module tb_vc_out_alloc;
    import noc_vc_pkg::*;

    localparam int VCN  = 2;
    localparam int NIN  = 5;
    localparam int FCPD = 1;
    localparam int N    = NIN * VCN;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req;
    logic [N-1:0]   req_gnt;
    logic [VCN-1:0] gnt_ovc;
    logic           flit_sent;
    logic [VCN-1:0] flit_ovc;
    logic           flit_tail;
    logic [VCN-1:0] credit;
    logic [VCN-1:0] ovc_busy;
    logic [VCN-1:0] ovc_cr_ok;
    logic           err;

    int tests = 0;
    int fails = 0;

    vc_out_alloc #(.VCN(VCN), .NIN(NIN), .FCPD(FCPD)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .req_gnt   (req_gnt),
        .gnt_ovc   (gnt_ovc),
        .flit_sent (flit_sent),
        .flit_ovc  (flit_ovc),
        .flit_tail (flit_tail),
        .credit    (credit),
        .ovc_busy  (ovc_busy),
        .ovc_cr_ok (ovc_cr_ok),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] rb(input int p, input int v);
        logic [N-1:0] one;
        one = 1;
        return one << req_idx(p, v, VCN);
    endfunction

    // Model: which output VCs are held, credits left, next requester to favour.
    int m_busy [VCN];
    int m_cnt  [VCN];
    int m_ptr, m_gidx, m_gvc, m_arm;
    bit m_err;
    int prev, fv, win, sv, nsel, r;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int v = 0; v < VCN; v++) begin
                m_busy[v] = 0;
                m_cnt[v]  = FCPD;
            end
            m_ptr = 0; m_gidx = -1; m_gvc = -1; m_err = 0; m_arm = 0;
        end else begin
            prev = m_gidx; sv = -1; fv = -1; win = -1;
            if (flit_sent) begin
                nsel = 0;
                for (int v = 0; v < VCN; v++)
                    if (flit_ovc[v]) begin nsel++; sv = v; end
                if (nsel != 1) begin m_err = 1; sv = -1; end
            end
            for (int v = 0; v < VCN; v++) begin
                if (sv == v && m_busy[v] == 0) m_err = 1;
                if (sv == v && m_busy[v] != 0) begin
                    if (!credit[v]) begin
                        if (m_cnt[v] == 0) m_err = 1;
                        else m_cnt[v] = m_cnt[v] - 1;
                    end
                end else if (credit[v]) begin
                    if (m_cnt[v] == FCPD) m_err = 1;
                    else m_cnt[v] = m_cnt[v] + 1;
                end
            end
            for (int v = 0; v < VCN; v++)
                if (fv < 0 && m_busy[v] == 0) fv = v;
            if (m_arm != 0 && fv >= 0) begin
                for (int k = 0; k < N; k++) begin
                    r = (m_ptr + k) % N;
                    if (win < 0 && req[r] && r != prev) win = r;
                end
            end
            if (sv >= 0 && flit_tail && m_busy[sv] != 0) m_busy[sv] = 0;
            if (win >= 0) begin
                m_busy[fv] = 1;
                m_ptr = (win + 1) % N;
                m_gvc = fv;
            end else begin
                m_gvc = -1;
            end
            m_gidx = win;
            m_arm = 1;
        end
    end

    logic [31:0] e_gnt, e_gvc, e_busy, e_crok;

    always @(posedge clk) begin
        #1;
        e_gnt  = (m_gidx >= 0) ? (32'd1 << m_gidx) : 32'd0;
        e_gvc  = (m_gvc  >= 0) ? (32'd1 << m_gvc)  : 32'd0;
        e_busy = 0;
        e_crok = 0;
        for (int v = 0; v < VCN; v++) begin
            if (m_busy[v] != 0) e_busy = e_busy | (32'd1 << v);
            if (m_cnt[v]  != 0) e_crok = e_crok | (32'd1 << v);
        end
        chk("cyc_req_gnt",   req_gnt,   e_gnt);
        chk("cyc_gnt_ovc",   gnt_ovc,   e_gvc);
        chk("cyc_ovc_busy",  ovc_busy,  e_busy);
        chk("cyc_ovc_cr_ok", ovc_cr_ok, e_crok);
        chk("cyc_err",       err,       m_err);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic flit(input logic [VCN-1:0] ovc, input logic tail);
        flit_sent = 1'b1;
        flit_ovc  = ovc;
        flit_tail = tail;
    endtask

    task automatic noflit();
        flit_sent = 1'b0;
        flit_ovc  = '0;
        flit_tail = 1'b0;
    endtask

    initial begin
        req = '0; credit = '0; noflit();
        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Reset values for two cycles
        step();
        chk("t1_busy", ovc_busy, 2'b00);
        chk("t1_crok", ovc_cr_ok, 2'b11);
        chk("t1_err", err, 1'b0);
        chk("t1_gnt_a", req_gnt, '0);
        step();
        chk("t1_gnt_b", req_gnt, '0);

        // Round-robin: bit0 then bit5, then bit2 waits for a tail
        req = rb(0, 0) | rb(2, 1);
        step();
        chk("t3_gnt0", req_gnt, 10'b00_0000_0001);
        chk("t3_ovc0", gnt_ovc, 2'b01);
        req = rb(2, 1);
        step();
        chk("t3_gnt5", req_gnt, 10'b00_0010_0000);
        chk("t3_ovc1", gnt_ovc, 2'b10);
        chk("t3_busy", ovc_busy, 2'b11);
        req = rb(1, 0);
        step();
        chk("t3_wait_a", req_gnt, '0);
        step();
        chk("t3_wait_b", req_gnt, '0);
        flit(2'b10, 1'b1);
        step();
        noflit();
        chk("t5_freed", ovc_busy, 2'b01);
        chk("t5_nobypass", req_gnt, '0);
        step();
        chk("t5_gnt2", req_gnt, 10'b00_0000_0100);
        chk("t5_ovc1", gnt_ovc, 2'b10);
        chk("model_ptr_a", m_ptr, 3);
        req = '0;

        // Return credits and free both VCs
        credit = 2'b10;
        step();
        credit = '0;
        flit(2'b01, 1'b1);
        step();
        noflit();
        credit = 2'b01;
        step();
        credit = '0;
        flit(2'b10, 1'b1);
        step();
        noflit();
        credit = 2'b10;
        step();
        credit = '0;
        chk("idle_busy", ovc_busy, 2'b00);
        chk("idle_crok", ovc_cr_ok, 2'b11);
        chk("idle_err", err, 1'b0);

        // Single request, held one edge too long
        req = rb(1, 1);
        step();
        chk("t2_gnt3", req_gnt, 10'b00_0000_1000);
        chk("t2_ovc", gnt_ovc, 2'b01);
        chk("t2_busy", ovc_busy, 2'b01);
        step();
        chk("t2_masked", req_gnt, '0);
        chk("t2_busy_hold", ovc_busy, 2'b01);
        req = '0;
        step();
        chk("t2_idle", req_gnt, '0);

        // Credits with depth 1
        flit(2'b01, 1'b0);
        step();
        noflit();
        chk("t4_crok_dec", ovc_cr_ok, 2'b10);
        credit = 2'b01;
        step();
        chk("t4_crok_ret", ovc_cr_ok, 2'b11);
        flit(2'b01, 1'b0);
        step();
        noflit();
        chk("t4_crok_same", ovc_cr_ok, 2'b11);
        chk("t4_err_same", err, 1'b0);
        step();
        credit = '0;
        chk("t4_err_ovf", err, 1'b1);
        chk("t4_crok_sat", ovc_cr_ok, 2'b11);
        chk("model_cnt0", m_cnt[0], FCPD);
        step();
        chk("t4_err_sticky", err, 1'b1);

        // Fill both VCs and drain credits, then reset mid-operation
        flit(2'b01, 1'b0);
        step();
        noflit();
        req = rb(3, 1);
        step();
        chk("t6_gnt7", req_gnt, 10'b00_1000_0000);
        req = '0;
        flit(2'b10, 1'b0);
        step();
        noflit();
        chk("t6_busy", ovc_busy, 2'b11);
        chk("t6_crok", ovc_cr_ok, 2'b00);
        req = rb(4, 1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_busy", ovc_busy, 2'b00);
        chk("t6_rst_crok", ovc_cr_ok, 2'b11);
        chk("t6_rst_err", err, 1'b0);
        chk("t6_rst_gnt", req_gnt, '0);
        chk("t6_rst_ovc", gnt_ovc, 2'b00);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("t6_first_cycle", req_gnt, '0);
        step();
        chk("t6_gnt9", req_gnt, 10'b10_0000_0000);
        chk("t6_ovc", gnt_ovc, 2'b01);
        chk("t6_busy_after", ovc_busy, 2'b01);
        req = '0;
        step();
        chk("t6_idle", req_gnt, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
